// File: rtl/gray_decoder.sv
// Two-stage gray-to-decimal decoder with thermometer output, step-direction
// detection and a saturating step-error counter, valid/ready on both sides.
module gray_decoder #(
    parameter int ERR_CNT_W  = 8,
    parameter bit CHECK_STEP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_gray,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_deci,
    output logic [6:0]           out_therm,
    output logic [1:0]           out_dir,
    output logic                 out_step_err,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [6:0] bin2therm(input logic [2:0] d);
        logic [6:0] t;
        case (d)
            3'd0:    t = 7'b0000000;
            3'd1:    t = 7'b0000001;
            3'd2:    t = 7'b0000011;
            3'd3:    t = 7'b0000111;
            3'd4:    t = 7'b0001111;
            3'd5:    t = 7'b0011111;
            3'd6:    t = 7'b0111111;
            3'd7:    t = 7'b1111111;
            default: t = 7'b0000000;
        endcase
        return t;
    endfunction

    logic                 adv_s;
    logic [2:0]           diff_s;
    logic [1:0]           dir_s;
    logic                 err_s;
    logic                 s1_valid_r;
    logic [2:0]           s1_deci_r;
    logic [2:0]           last_deci_r;
    logic                 have_last_r;
    logic                 out_valid_r;
    logic [2:0]           out_deci_r;
    logic [6:0]           out_therm_r;
    logic [1:0]           out_dir_r;
    logic                 out_step_err_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;

    assign adv_s        = !out_valid_r | out_ready;
    assign in_ready     = adv_s & en;
    assign out_valid    = out_valid_r;
    assign out_deci     = out_deci_r;
    assign out_therm    = out_therm_r;
    assign out_dir      = out_dir_r;
    assign out_step_err = out_step_err_r;
    assign err_cnt      = err_cnt_r;

    // Step classification of the stage-1 sample against the last reference value
    always_comb begin
        diff_s = s1_deci_r - last_deci_r;
        dir_s  = 2'b00;
        err_s  = 1'b0;
        if (have_last_r) begin
            case (diff_s)
                3'd0:    dir_s = 2'b00;
                3'd1:    dir_s = 2'b01;
                3'd7:    dir_s = 2'b10;
                default: err_s = CHECK_STEP;
            endcase
        end else begin
            dir_s = 2'b00;
            err_s = 1'b0;
        end
    end

    // Pipeline stages and reference tracking; everything holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r     <= 1'b0;
            s1_deci_r      <= 3'd0;
            last_deci_r    <= 3'd0;
            have_last_r    <= 1'b0;
            out_valid_r    <= 1'b0;
            out_deci_r     <= 3'd0;
            out_therm_r    <= 7'd0;
            out_dir_r      <= 2'b00;
            out_step_err_r <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r  <= in_valid & en;
            if (in_valid & en) begin
                s1_deci_r <= gray2bin(in_gray);
            end
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_deci_r     <= s1_deci_r;
                out_therm_r    <= bin2therm(s1_deci_r);
                out_dir_r      <= dir_s;
                out_step_err_r <= err_s;
                last_deci_r    <= s1_deci_r;
                have_last_r    <= 1'b1;
            end
        end
    end

    // Saturating error counter; clear wins over a coincident increment
    always_ff @(posedge clk) begin
        if (rst || clr_err || !CHECK_STEP) begin
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if (adv_s && s1_valid_r && err_s && (err_cnt_r != CNT_MAX)) begin
            err_cnt_r <= err_cnt_r + CNT_ONE;
        end
    end

endmodule
